// File: rtl/dm_bus_arbiter_pkg.sv
// dm_bus_arbiter_pkg
//   Shared definitions for the data-memory bus arbiter:
//   - BIT_WIDTH_P : default address/data width, taken from `BIT_WIDTH
//   - arb_state_e : arbiter FSM state encoding
//   - CTRL_*      : bit positions inside the 3-bit ControlBus {we, re, regwe}
//   - ctrl_valid(): a control word names a memory access when we or re is set
`ifndef BIT_WIDTH
`define BIT_WIDTH 64
`endif

package dm_bus_arbiter_pkg;

    localparam int unsigned BIT_WIDTH_P = `BIT_WIDTH;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam int unsigned CTRL_WE    = 2;
    localparam int unsigned CTRL_RE    = 1;
    localparam int unsigned CTRL_REGWE = 0;

    function automatic logic ctrl_valid(input logic [2:0] ctrl);
        return ctrl[CTRL_WE] | ctrl[CTRL_RE];
    endfunction

endpackage

// File: rtl/dm_bus_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin picker.
//   Ports:
//     valid [1:0] in  : valid request per master
//     last        in  : master granted most recently
//     any         out : at least one valid request
//     gnt         out : chosen master (meaningful only when any=1)
//   On a tie the master that was not granted last wins.
module rr_pick2
    import dm_bus_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic       any,
    output logic       gnt
);

    always_comb begin
        any = valid[0] | valid[1];
        if (valid == 2'b11) begin
            gnt = ~last;
        end else begin
            gnt = valid[1];
        end
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter
//   Shares one fixed-latency data-memory port between the CPU load/store bus
//   (master 0) and the loader/debug DMA (master 1), granted round-robin.
//   Ports:
//     clk, rst                 : clock (rising edge), synchronous active-high reset
//     mN_req/addr/wdata/ctrl   : master N request; ctrl = {we, re, regwe}
//     mN_rdata, mN_ack         : one-cycle completion pulse with read data
//     mN_stall                 : request pending and not yet acknowledged
//     mem_addr/wdata/we/re     : memory command
//     mem_rdata                : memory read data, sampled MEM_LATENCY cycles in
//   One access takes MEM_LATENCY+2 cycles: IDLE (grant), MEM_LATENCY x BUSY, DONE.
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int unsigned BIT_W       = BIT_WIDTH_P,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_req,
    input  logic [BIT_W-1:0] m0_addr,
    input  logic [BIT_W-1:0] m0_wdata,
    input  logic [2:0]       m0_ctrl,
    output logic [BIT_W-1:0] m0_rdata,
    output logic             m0_ack,
    output logic             m0_stall,

    input  logic             m1_req,
    input  logic [BIT_W-1:0] m1_addr,
    input  logic [BIT_W-1:0] m1_wdata,
    input  logic [2:0]       m1_ctrl,
    output logic [BIT_W-1:0] m1_rdata,
    output logic             m1_ack,
    output logic             m1_stall,

    output logic [BIT_W-1:0] mem_addr,
    output logic [BIT_W-1:0] mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [BIT_W-1:0] mem_rdata
);

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("dm_bus_arbiter: MEM_LATENCY must be at least 1");
    end
    if (longint'(MEM_LATENCY) > (64'sd1 <<< CNT_W)) begin : g_bad_cnt_w
        $error("dm_bus_arbiter: CNT_W too narrow for MEM_LATENCY");
    end

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] addr_q, addr_d;
    logic [BIT_W-1:0] wdata_q, wdata_d;
    logic [BIT_W-1:0] rdata_q, rdata_d;
    logic             write_q, write_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;

    logic [1:0]       valid;
    logic             pick_any;
    logic             pick_gnt;

    // regwe plays no part in a memory access
    logic             unused_regwe;
    assign unused_regwe = m0_ctrl[CTRL_REGWE] ^ m1_ctrl[CTRL_REGWE];

    assign valid = {m1_req & ctrl_valid(m1_ctrl), m0_req & ctrl_valid(m0_ctrl)};

    rr_pick2 u_pick (
        .valid (valid),
        .last  (last_q),
        .any   (pick_any),
        .gnt   (pick_gnt)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (pick_any)      state_d = ARB_BUSY;
            ARB_BUSY: if (cnt_q == '0)   state_d = ARB_DONE;
            ARB_DONE:                    state_d = ARB_IDLE;
            default:                     state_d = ARB_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    addr_d  = pick_gnt ? m1_addr  : m0_addr;
                    wdata_d = pick_gnt ? m1_wdata : m0_wdata;
                    // we=re=1 is performed as a write
                    write_d = pick_gnt ? m1_ctrl[CTRL_WE] : m0_ctrl[CTRL_WE];
                    cnt_d   = LAT_M1;
                end
            end
            ARB_BUSY: begin
                if (cnt_q == '0) begin
                    rdata_d = write_q ? '0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ARB_DONE: begin
                last_d = gnt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        case (state_q)
            ARB_BUSY: begin
                mem_re = ~write_q;
                // cnt still holds its load value only in the first BUSY cycle
                mem_we = write_q & (cnt_q == LAT_M1);
            end
            ARB_DONE: begin
                if (gnt_q) begin
                    m1_ack   = 1'b1;
                    m1_rdata = rdata_q;
                end else begin
                    m0_ack   = 1'b1;
                    m0_rdata = rdata_q;
                end
            end
            default: ;
        endcase
    end

    assign m0_stall = valid[0] & ~m0_ack;
    assign m1_stall = valid[1] & ~m1_ack;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter
//   Drives both masters and the memory read data, and compares every DUT
//   output each cycle against a transaction-level model: a granted access
//   is a record {who, write, addr, wdata, grant cycle t}, with BUSY cycles
//   t+1..t+LAT, read data taken from the memory value of cycle t+LAT and
//   the ack in cycle t+LAT+1.
module tb_dm_bus_arbiter;

    localparam int unsigned W    = 64;
    localparam int unsigned LAT  = 3;
    localparam int          NCYC = 2000;
    localparam int          PHASE_A = 30;  // continuous reads from both masters
    localparam int          RST_AT  = 8;   // second BUSY cycle of the m1 read

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic         m0_ack, m1_ack, m0_stall, m1_stall, mem_we, mem_re;

    logic         mreq   [2];
    logic [W-1:0] maddr  [2];
    logic [W-1:0] mwdata [2];
    logic [2:0]   mctrl  [2];

    always #5 clk = ~clk;

    dm_bus_arbiter #(
        .BIT_W       (W),
        .MEM_LATENCY (LAT),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (mreq[0]),
        .m0_addr   (maddr[0]),
        .m0_wdata  (mwdata[0]),
        .m0_ctrl   (mctrl[0]),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m0_stall  (m0_stall),
        .m1_req    (mreq[1]),
        .m1_addr   (maddr[1]),
        .m1_wdata  (mwdata[1]),
        .m1_ctrl   (mctrl[1]),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .m1_stall  (m1_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // transaction-level reference state
    bit           busy;
    int           t;
    bit           who;
    bit           wr;
    bit           last;
    logic [W-1:0] lat_a, lat_d;
    logic [W-1:0] memrd [NCYC+1];

    initial begin
        rst       = 1'b1;
        mem_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 1'b0; maddr[m] = '0; mwdata[m] = '0; mctrl[m] = 3'b000;
        end
        repeat (2) @(posedge clk);
        #1;
        busy = 1'b0; t = 0; who = 1'b0; wr = 1'b0; last = 1'b1;
        lat_a = '0; lat_d = '0;

        for (int c = 0; c < NCYC; c++) begin
            bit ack_e [2];
            bit v     [2];
            bit busy_ph, done_ph;
            logic [W-1:0] rd_e;
            cyc = c;
            memrd[c] = mem_rdata;
            @(negedge clk);
            busy_ph = busy && (c >= t + 1) && (c <= t + int'(LAT));
            done_ph = busy && (c == t + int'(LAT) + 1);
            rd_e    = (done_ph && !wr) ? memrd[t + int'(LAT)] : '0;
            for (int m = 0; m < 2; m++) begin
                ack_e[m] = done_ph && (int'(who) == m);
                v[m]     = mreq[m] && (mctrl[m][2] || mctrl[m][1]);
            end
            check_eq("mem_re",    W'(mem_re),   W'(busy_ph && !wr));
            check_eq("mem_we",    W'(mem_we),   W'(busy_ph && wr && c == t + 1));
            check_eq("mem_addr",  mem_addr,     lat_a);
            check_eq("mem_wdata", mem_wdata,    lat_d);
            check_eq("m0_ack",    W'(m0_ack),   W'(ack_e[0]));
            check_eq("m1_ack",    W'(m1_ack),   W'(ack_e[1]));
            check_eq("m0_rdata",  m0_rdata,     ack_e[0] ? rd_e : '0);
            check_eq("m1_rdata",  m1_rdata,     ack_e[1] ? rd_e : '0);
            check_eq("m0_stall",  W'(m0_stall), W'(v[0] && !ack_e[0]));
            check_eq("m1_stall",  W'(m1_stall), W'(v[1] && !ack_e[1]));

            @(posedge clk);
            if (rst) begin
                busy = 1'b0; last = 1'b1; lat_a = '0; lat_d = '0;
            end else if (done_ph) begin
                busy = 1'b0; last = who;
            end else if (!busy && (v[0] || v[1])) begin
                who   = (v[0] && v[1]) ? !last : v[1];
                wr    = mctrl[who][2];
                lat_a = maddr[who];
                lat_d = mwdata[who];
                t     = c;
                busy  = 1'b1;
            end

            #1;
            if (c + 1 < PHASE_A) rst = (c + 1 == RST_AT);
            else                 rst = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < 2; m++) begin
                if (c + 1 < PHASE_A) begin
                    mreq[m]   = 1'b1;
                    mctrl[m]  = 3'b010;
                    maddr[m]  = W'(64 + 64 * m);
                    mwdata[m] = '0;
                end else if (!mreq[m]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        mreq[m]   = 1'b1;
                        maddr[m]  = {$urandom, $urandom};
                        mwdata[m] = {$urandom, $urandom};
                        mctrl[m]  = 3'($urandom_range(0, 7));
                    end
                end else if (ack_e[m]) begin
                    if ($urandom_range(0, 1) == 0) mreq[m] = 1'b0;
                end else if (!v[m]) begin
                    if ($urandom_range(0, 3) == 0) mreq[m] = 1'b0;
                end else if ($urandom_range(0, 31) == 0) begin
                    mreq[m] = 1'b0;
                end
            end
            mem_rdata = {$urandom, $urandom};
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
